// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with an in-order prediction queue and mispredict redirect.
// Optional statistics counters are built when FETCH_PC_STATS_EN is defined.
module fetch_pc_unit #(
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 bp_hit_i,
  input  logic                 bp_taken_i,
  input  logic [ADDR_SIZE-1:0] bp_target_i,
  input  logic                 res_valid_i,
  input  logic                 res_is_branch_i,
  input  logic                 res_taken_i,
  input  logic [ADDR_SIZE-1:0] res_target_i,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 pc_valid_o,
  output logic                 flush_o,
  output logic                 queue_full_o,
  output logic [15:0]          branch_cnt_o,
  output logic [15:0]          mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] pred_next;
  } pq_entry_t;

  pq_entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic                 flush_q, flush_d;

  pq_entry_t            head;
  logic                 q_empty, q_full, pop, mispredict, issue;
  logic [ADDR_SIZE-1:0] pred_next, actual_next;

  // Source selection, resolve comparison and issue qualification
  always_comb begin
    q_empty     = (rd_q == wr_q);
    q_full      = (rd_q[IDX_W-1:0] == wr_q[IDX_W-1:0]) && (rd_q[IDX_W] != wr_q[IDX_W]);
    head        = mem_q[rd_q[IDX_W-1:0]];
    pred_next   = (bp_hit_i && bp_taken_i) ? bp_target_i : pc_q + ADDR_SIZE'(4);
    pop         = res_valid_i && !q_empty;
    actual_next = (res_is_branch_i && res_taken_i) ? res_target_i : head.pc + ADDR_SIZE'(4);
    mispredict  = pop && (actual_next != head.pred_next);
    issue       = !stall_i && !(q_full && !res_valid_i) && !mispredict;
  end

  // Next-state: a redirect overrides both the predictor and stall, and empties the queue
  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    flush_d = 1'b0;
    if (mispredict) begin
      pc_d    = actual_next;
      rd_d    = '0;
      wr_d    = '0;
      flush_d = 1'b1;
    end else begin
      if (issue) begin
        pc_d = pred_next;
        wr_d = wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      flush_q <= flush_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (issue) begin
      mem_q[wr_q[IDX_W-1:0]] <= '{pc: pc_q, pred_next: pred_next};
    end
  end

  assign pc_o         = pc_q;
  assign flush_o      = flush_q;
  assign pc_valid_o   = issue;
  assign queue_full_o = q_full;

`ifdef FETCH_PC_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (pop && res_is_branch_i && (branch_cnt_q != {CNT_W{1'b1}})) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: per-cycle expectations go through a scoreboard queue
// and are checked at the falling edge; counter checks follow FETCH_PC_STATS_EN.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, bp_hit, bp_taken, res_valid, res_is_branch, res_taken;
  logic [31:0] bp_target, res_target;
  logic [31:0] pc;
  logic        pc_valid, flush, queue_full;
  logic [15:0] branch_cnt, mispredict_cnt;

`ifdef FETCH_PC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  fetch_pc_unit #(.ADDR_SIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .bp_hit_i        (bp_hit),
    .bp_taken_i      (bp_taken),
    .bp_target_i     (bp_target),
    .res_valid_i     (res_valid),
    .res_is_branch_i (res_is_branch),
    .res_taken_i     (res_taken),
    .res_target_i    (res_target),
    .pc_o            (pc),
    .pc_valid_o      (pc_valid),
    .flush_o         (flush),
    .queue_full_o    (queue_full),
    .branch_cnt_o    (branch_cnt),
    .mispredict_cnt_o(mispredict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] b, input logic [15:0] m);
    chk({tag, ".branch_cnt"}, 32'(branch_cnt), STATS ? 32'(b) : 32'h0);
    chk({tag, ".mispredict_cnt"}, 32'(mispredict_cnt), STATS ? 32'(m) : 32'h0);
  endtask

  // One cycle: drive inputs, enqueue the expected outputs, compare at negedge, advance
  task automatic cyc(input string tag,
                     input logic s, input logic h, input logic t, input logic [31:0] tg,
                     input logic rv, input logic rb, input logic rt, input logic [31:0] rtg,
                     input logic [31:0] e_pc, input logic e_valid, input logic e_flush,
                     input logic e_full);
    exp_t e;
    stall = s; bp_hit = h; bp_taken = t; bp_target = tg;
    res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtg;
    sb.push_back('{pc: e_pc, valid: e_valid, flush: e_flush, full: e_full});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(e.valid));
    chk({tag, ".flush"}, 32'(flush), 32'(e.flush));
    chk({tag, ".queue_full"}, 32'(queue_full), 32'(e.full));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0; bp_hit = 1'b0; bp_taken = 1'b0; bp_target = '0;
    res_valid = 1'b0; res_is_branch = 1'b0; res_taken = 1'b0; res_target = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    chk("rst.pc", pc, 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.full", 32'(queue_full), 32'h0);
    chk_cnt("rst", 16'd0, 16'd0);

    // Sequential fetch, non-branch resolves from the second cycle
    cyc("c1",  0,0,0,32'h0,  0,0,0,32'h0,  32'h0,  1,0,0);
    cyc("c2",  0,0,0,32'h0,  1,0,0,32'h0,  32'h4,  1,0,0);
    cyc("c3",  0,0,0,32'h0,  1,0,0,32'h0,  32'h8,  1,0,0);
    cyc("c4",  0,0,0,32'h0,  1,0,0,32'h0,  32'hC,  1,0,0);
    // Taken prediction confirmed by resolve: no flush
    cyc("c5",  0,1,1,32'h40, 1,0,0,32'h0,  32'h10, 1,0,0);
    cyc("c6",  0,0,0,32'h0,  1,1,1,32'h40, 32'h40, 1,0,0);
    cyc("c7",  0,0,0,32'h0,  1,0,0,32'h0,  32'h44, 1,0,0);
    // Taken prediction resolved not-taken: redirect to fall-through
    cyc("c8",  0,1,1,32'h80, 1,0,0,32'h0,  32'h48, 1,0,0);
    cyc("c9",  0,0,0,32'h0,  1,1,0,32'h0,  32'h80, 0,0,0);
    chk_cnt("c9", 16'd2, 16'd1);
    cyc("c10", 0,0,0,32'h0,  0,0,0,32'h0,  32'h4C, 1,1,0);
    // Unpredicted branch resolved taken
    cyc("c11", 0,0,0,32'h0,  1,1,1,32'h100,32'h50, 0,0,0);
    chk_cnt("c11", 16'd3, 16'd2);
    cyc("c12", 0,0,0,32'h0,  0,0,0,32'h0,  32'h100,1,1,0);
    // Stall holds pc; resolve still pops during stall; resolve on empty queue ignored
    cyc("c13", 1,0,0,32'h0,  0,0,0,32'h0,  32'h104,0,0,0);
    cyc("c14", 1,0,0,32'h0,  1,0,0,32'h0,  32'h104,0,0,0);
    cyc("c15", 0,0,0,32'h0,  1,1,1,32'h300,32'h104,1,0,0);
    chk_cnt("c15", 16'd3, 16'd2);
    cyc("c16", 0,0,0,32'h0,  0,0,0,32'h0,  32'h108,1,0,0);

    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst2.pc", pc, 32'h0);
    chk("rst2.full", 32'(queue_full), 32'h0);
    chk_cnt("rst2", 16'd0, 16'd0);

    // Fill the queue, then pop+push while full
    cyc("f1",  0,0,0,32'h0,  0,0,0,32'h0,  32'h0,  1,0,0);
    cyc("f2",  0,0,0,32'h0,  0,0,0,32'h0,  32'h4,  1,0,0);
    cyc("f3",  0,0,0,32'h0,  0,0,0,32'h0,  32'h8,  1,0,0);
    cyc("f4",  0,0,0,32'h0,  0,0,0,32'h0,  32'hC,  1,0,0);
    cyc("f5",  0,0,0,32'h0,  0,0,0,32'h0,  32'h10, 0,0,1);
    cyc("f6",  0,0,0,32'h0,  0,0,0,32'h0,  32'h10, 0,0,1);
    cyc("f7",  0,0,0,32'h0,  1,0,0,32'h0,  32'h10, 1,0,1);
    cyc("f8",  0,0,0,32'h0,  1,0,0,32'h0,  32'h14, 1,0,1);
    cyc("f9",  0,0,0,32'h0,  1,1,1,32'h200,32'h18, 0,0,1);
    chk_cnt("f9", 16'd1, 16'd1);
    // Reset asserted during the flush cycle
    rst = 1'b0;
    cyc("f10", 0,0,0,32'h0,  0,0,0,32'h0,  32'h200,1,1,0);
    rst = 1'b1;
    chk_cnt("f10", 16'd0, 16'd0);
    cyc("f11", 0,0,0,32'h0,  0,0,0,32'h0,  32'h0,  1,0,0);
    // Redirect to the top of the address space, then wrap to zero
    cyc("f12", 0,0,0,32'h0,  1,1,1,32'hFFFFFFFC, 32'h4, 0,0,0);
    chk_cnt("f12", 16'd1, 16'd1);
    cyc("f13", 0,0,0,32'h0,  0,0,0,32'h0,  32'hFFFFFFFC, 1,1,0);
    cyc("f14", 0,0,0,32'h0,  1,0,0,32'h0,  32'h0,  1,0,0);
    cyc("f15", 0,0,0,32'h0,  0,0,0,32'h0,  32'h4,  1,0,0);
    chk_cnt("f15", 16'd1, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
